// File: rtl/video_framebuffer_reader_pkg.sv
// Shared types and defaults for the framebuffer read path.
// Carries the VGA geometry/colour macros and the reader FSM encoding.
`ifndef VGA_SVH
`define VGA_SVH
`define R_SIZE 4
`define G_SIZE 4
`define B_SIZE 4
`define RGB_SIZE (`R_SIZE + `G_SIZE + `B_SIZE)
`define H_DISPLAY 640
`define V_DISPLAY 480
`endif

package video_framebuffer_reader_pkg;

  localparam int RGB_W         = `RGB_SIZE;
  localparam int DEF_H_DISPLAY = `H_DISPLAY;
  localparam int DEF_V_DISPLAY = `V_DISPLAY;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} fb_rd_state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/video_fifo_sync.sv
// Synchronous show-ahead FIFO: rd_data always presents the head entry.
// DEPTH must be a power of two so the pointers wrap naturally.
module video_fifo_sync
  import video_framebuffer_reader_pkg::*;
#(
  parameter  int WIDTH = RGB_W,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_ok;
  logic             rd_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign rd_ok   = rd_en && !empty;
  // A full FIFO still accepts a write when the head leaves on the same edge.
  assign wr_ok   = wr_en && (!full || rd_en);
  assign rd_data = mem[rd_ptr];

  // NOTE: the storage array has no reset; only pointers and count need a known state.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  // NOTE: sequential state always uses non-blocking assignments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      unique case ({wr_ok, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/video_framebuffer_reader.sv
// Avalon-MM read master streaming a framebuffer in raster order as valid/ready pixels.
// Reads are credit-limited so every returning datum is guaranteed a buffer slot.
module video_framebuffer_reader
  import video_framebuffer_reader_pkg::*;
#(
  parameter int          AVN_AW    = 19,
  parameter int          AVN_DW    = 16,
  parameter int          H_DISPLAY = DEF_H_DISPLAY,
  parameter int          V_DISPLAY = DEF_V_DISPLAY,
  parameter int unsigned FB_BASE   = 0,
  parameter int          BUF_SIZE  = 16
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                enable,
  output logic                avn_read,
  output logic [AVN_AW-1:0]   avn_address,
  output logic [AVN_DW/8-1:0] avn_byteenable,
  input  logic                avn_waitrequest,
  input  logic [AVN_DW-1:0]   avn_readdata,
  input  logic                avn_readdatavalid,
  output logic                pix_vld,
  input  logic                pix_rdy,
  output logic [RGB_W-1:0]    pix_rgb,
  output logic                pix_sof,
  output logic                pix_eol,
  output logic                busy,
  output logic                err
);

  localparam int                CW        = $clog2(BUF_SIZE) + 1;
  localparam int                HW        = cnt_w(H_DISPLAY);
  localparam int                VW        = cnt_w(V_DISPLAY);
  localparam logic [AVN_AW-1:0] BASE_ADDR = AVN_AW'(FB_BASE);
  localparam logic [AVN_AW-1:0] LAST_ADDR = AVN_AW'(FB_BASE + H_DISPLAY * V_DISPLAY - 1);
  localparam logic [CW:0]       BUF_LIMIT = (CW + 1)'(BUF_SIZE);

  fb_rd_state_t      state_q, state_d;
  logic              read_d;
  logic [AVN_AW-1:0] addr_d;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     buf_count;
  logic              buf_full;
  logic              buf_empty;
  logic [RGB_W-1:0]  head_rgb;
  logic [HW-1:0]     ohc;
  logic [VW-1:0]     ovc;
  logic              accept;
  logic              last_accept;
  logic              push;
  logic              pop;
  logic [CW:0]       committed;
  logic              credit_ok;
  logic              unused_bits;

  assign accept      = avn_read && !avn_waitrequest;
  assign last_accept = accept && (avn_address == LAST_ADDR);
  // Data arriving with nothing outstanding is dropped instead of underflowing.
  assign push        = avn_readdatavalid && (outstanding != '0);
  assign pop         = pix_vld && pix_rdy;
  assign committed   = {1'b0, outstanding} + {1'b0, buf_count} + (CW + 1)'(accept);
  assign credit_ok   = committed < BUF_LIMIT;

  assign avn_byteenable = '1;
  assign busy           = (state_q != IDLE);
  assign pix_vld        = !buf_empty;
  assign pix_rgb        = pix_vld ? head_rgb : '0;
  assign pix_sof        = pix_vld && (ohc == '0) && (ovc == '0);
  assign pix_eol        = pix_vld && (ohc == HW'(H_DISPLAY - 1));
  assign unused_bits    = ^{avn_readdata[AVN_DW-1:RGB_W], buf_full};

  video_fifo_sync #(
    .WIDTH (RGB_W),
    .DEPTH (BUF_SIZE)
  ) u_fifo (
    .clk     (sys_clk),
    .rst_n   (sys_rst),
    .wr_en   (push),
    .wr_data (avn_readdata[RGB_W-1:0]),
    .rd_en   (pop),
    .rd_data (head_rgb),
    .count   (buf_count),
    .full    (buf_full),
    .empty   (buf_empty)
  );

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_d = state_q;
    read_d  = 1'b0;
    addr_d  = avn_address;
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = FETCH;
          addr_d  = BASE_ADDR;
          read_d  = credit_ok;
        end
      end
      FETCH: begin
        if (accept) addr_d = last_accept ? BASE_ADDR : avn_address + AVN_AW'(1);
        if (last_accept && !enable) begin
          state_d = DRAIN;
        end else begin
          // A stalled request must stay up until the slave takes it.
          read_d = (avn_read && avn_waitrequest) || credit_ok;
        end
      end
      DRAIN: begin
        if (outstanding == '0 && buf_empty) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q     <= IDLE;
      avn_read    <= 1'b0;
      avn_address <= BASE_ADDR;
      outstanding <= '0;
      err         <= 1'b0;
    end else begin
      state_q     <= state_d;
      avn_read    <= read_d;
      avn_address <= addr_d;
      unique case ({accept, push})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
      if (avn_readdatavalid && outstanding == '0) err <= 1'b1;
    end
  end

  // Output tags follow the consumer, so frames stay aligned across IDLE.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      ohc <= '0;
      ovc <= '0;
    end else if (pop) begin
      if (ohc == HW'(H_DISPLAY - 1)) begin
        ohc <= '0;
        ovc <= (ovc == VW'(V_DISPLAY - 1)) ? '0 : ovc + VW'(1);
      end else begin
        ohc <= ohc + HW'(1);
      end
    end
  end

endmodule
